eth_phy_10g_rx_link_ctrl: RTL
=============================

// Module: eth_phy_10g_rx_link_ctrl
// PURPOSE
//  Supervisor that sequences the 10G RX SerDes and the sync-header block aligner.
//  - Holds SerDes RX and aligner in reset, waits for block lock, qualifies the link.
//  - Monitors sync-header errors per clause-49 style BER window; raises hi_ber.
//  - Forces a full resync on lock timeout, persistent hi_ber or a software request.
// PARAMETERS
//  HDR_WIDTH          2      sync header width
//  SERDES_RST_CYCLES  16     cycles SerDes and aligner resets are held, >=2
//  LOCK_TIMEOUT       65536  cycles allowed in WAIT_LOCK before retry, >=2
//  BER_WINDOW         19531  window length in cycles (125 us at 156.25 MHz)
//  BER_THRESH         16     bad headers per window that assert hi_ber, >=1
//  HIBER_LIMIT        8      consecutive hi_ber windows before forced resync, >=1
//  CNT_WIDTH          8      width of retry and relock statistics counters
// PORTS
//  clk                 in   1          clock
//  rst                 in   1          synchronous reset, active-high
//  i_rx_hdr            in   HDR_WIDTH  aligned sync header from aligner, one per clk
//  i_rx_block_lock     in   1          aligner block-lock flag
//  i_force_resync      in   1          single-cycle pulse: restart from RESET
//  o_serdes_rx_reset   out  1          SerDes RX reset request
//  o_aligner_rst       out  1          aligner synchronous reset
//  o_rx_status         out  1          link up: locked and not hi_ber
//  o_rx_high_ber       out  1          hi_ber indication
//  o_retry_count       out  CNT_WIDTH  lock-timeout and forced resyncs, saturating
//  o_relock_count      out  CNT_WIDTH  lock losses from UP or HI_BER, saturating
// BEHAVIOUR
//  - Reset is synchronous, active-high on rst; clock is clk. All outputs are registered.
//  - Output values while rst is high:
//    - o_serdes_rx_reset=1, o_aligner_rst=1.
//    - o_rx_status=0, o_rx_high_ber=0.
//    - o_retry_count=0, o_relock_count=0.
//  - After rst falls: state=RESET, all timers=0.
//  - Bad header: i_rx_hdr not 2'b01 or 2'b10 while i_rx_block_lock=1.
//  - BER monitor: window counter counts 0..BER_WINDOW-1, then wraps.
//    - bad_cnt saturates at BER_THRESH.
//    - On the wrap cycle, bad_cnt restarts at 0, or at 1 if that cycle is bad.
//    - window_end is a pulse on the wrap cycle. It reports the count of the closing window.
//    - Monitor runs only in QUALIFY, UP and HI_BER. Both counters are cleared on entry to QUALIFY.
//  - States and transitions (priority top to bottom within each state):
//    RESET      serdes_rst=1, aligner_rst=1.
//               Once SERDES_RST_CYCLES cycles have elapsed -> WAIT_LOCK.
//    WAIT_LOCK  resets deasserted; lock timer counts.
//               i_rx_block_lock=1 -> QUALIFY.
//               Timer reaches LOCK_TIMEOUT-1 -> RESET and retry_count+1.
//    QUALIFY    lock=0 -> WAIT_LOCK.
//               window_end with bad<BER_THRESH -> UP; otherwise restart the window.
//    UP         o_rx_status=1.
//               lock=0 -> WAIT_LOCK and relock_count+1.
//               bad_cnt reaches BER_THRESH -> HI_BER the next cycle, hiber_cnt=0.
//    HI_BER     o_rx_high_ber=1, o_rx_status=0.
//               lock=0 -> WAIT_LOCK and relock_count+1.
//               window_end with bad<BER_THRESH -> UP.
//               window_end with bad>=BER_THRESH -> hiber_cnt+1.
//               hiber_cnt reaches HIBER_LIMIT -> RESET and retry_count+1.
//  - i_force_resync in any state -> RESET next cycle and retry_count+1.
//    It overrides all other transitions in the same cycle.
//  - Entering WAIT_LOCK clears the lock timer. Entering RESET clears the reset timer.
//  - Status outputs follow the state register with no extra cycle.
//  - Counters saturate at all-ones. They clear only on rst.
//  - Timer widths use $clog2 of each parameter. There is no arithmetic wrap beyond the terminal value.
// STRUCTURE
//  - Shared package eth_phy_10g_pkg holds:
//    - SYNC_DATA = 2'b10 and SYNC_CTRL = 2'b01.
//    - Link controller state encoding: RESET, WAIT_LOCK, QUALIFY, UP, HI_BER.
//  - Sub-module eth_phy_10g_ber_mon contains the window counter and the bad-header counter.
//    - Inputs: clk, rst, clear, enable, bad.
//    - Outputs: window_end, bad_cnt, thresh_hit.
//  - The top level holds the FSM, the timers and the statistics counters.
// TESTING
//  Bench parameters: SERDES_RST_CYCLES=4, LOCK_TIMEOUT=32, BER_WINDOW=64, BER_THRESH=4,
//  HIBER_LIMIT=2.
//  1. rst, then lock at cycle 10 with clean headers.
//     -> both resets high for 4 cycles after rst.
//     -> QUALIFY for 64 cycles, then o_rx_status=1.
//  2. Lock never asserted.
//     -> RESET every 4+32 cycles; o_retry_count increments 1, 2, 3.
//  3. In UP, inject 4 bad headers within one window.
//     -> o_rx_high_ber=1 one cycle after the 4th bad header; o_rx_status=0.
//     -> Next window clean -> UP.
//  4. In HI_BER, 4 bad headers per window for 2 windows.
//     -> RESET, o_retry_count+1, o_serdes_rx_reset=1.
//  5. Drop i_rx_block_lock in UP.
//     -> WAIT_LOCK next cycle; o_relock_count=1.
//     -> Relock, then 64 cycles later o_rx_status=1.
//  6. Edge cases:
//     -> i_force_resync coincident with window_end -> RESET wins.
//     -> A bad header on the wrap cycle counts in the new window.
//     -> rst mid-QUALIFY returns all outputs to their reset values.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10G PHY receive path: sync-header codes and
// link-controller state encoding.
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        QUALIFY,
        UP,
        HI_BER
    } link_state_e;

endpackage

// File: rtl/eth_phy_10g_ber_mon.sv
// BER window monitor: free-running window counter plus a saturating count of
// bad sync headers seen in the current window.
module eth_phy_10g_ber_mon #(
    parameter int unsigned BER_WINDOW = 19531,
    parameter int unsigned BER_THRESH = 16,
    localparam int unsigned WIN_W = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1,
    localparam int unsigned BAD_W = $clog2(BER_THRESH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             bad,
    output logic             window_end,
    output logic [BAD_W-1:0] bad_cnt,
    output logic             thresh_hit
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
    localparam logic [BAD_W-1:0] THRESH   = BAD_W'(BER_THRESH);

    logic [WIN_W-1:0] win_q, win_d;
    logic [BAD_W-1:0] bad_q, bad_d;
    logic             wrap;

    always_comb begin
        wrap  = enable && (win_q == WIN_LAST);
        win_d = win_q;
        bad_d = bad_q;
        if (clear) begin
            win_d = '0;
            bad_d = '0;
        end else if (enable) begin
            if (wrap) begin
                // the wrap cycle already belongs to the next window
                win_d = '0;
                bad_d = bad ? BAD_W'(1) : '0;
            end else begin
                win_d = win_q + WIN_W'(1);
                if (bad && (bad_q != THRESH)) begin
                    bad_d = bad_q + BAD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '0;
            bad_q <= '0;
        end else begin
            win_q <= win_d;
            bad_q <= bad_d;
        end
    end

    // window_end reports the closing window via bad_cnt; thresh_hit looks ahead
    // so the controller can react on the cycle the threshold is crossed.
    assign window_end = wrap;
    assign bad_cnt    = bad_q;
    assign thresh_hit = (bad_d >= THRESH);

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10G RX link supervisor: sequences SerDes/aligner resets, qualifies block
// lock, tracks hi_ber and forces resyncs, with saturating statistics.
module eth_phy_10g_rx_link_ctrl #(
    parameter int unsigned HDR_WIDTH         = 2,
    parameter int unsigned SERDES_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT      = 65536,
    parameter int unsigned BER_WINDOW        = 19531,
    parameter int unsigned BER_THRESH        = 16,
    parameter int unsigned HIBER_LIMIT       = 8,
    parameter int unsigned CNT_WIDTH         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] i_rx_hdr,
    input  logic                 i_rx_block_lock,
    input  logic                 i_force_resync,
    output logic                 o_serdes_rx_reset,
    output logic                 o_aligner_rst,
    output logic                 o_rx_status,
    output logic                 o_rx_high_ber,
    output logic [CNT_WIDTH-1:0] o_retry_count,
    output logic [CNT_WIDTH-1:0] o_relock_count
);

    import eth_phy_10g_pkg::*;

    localparam int unsigned RST_W  = $clog2(SERDES_RST_CYCLES);
    localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT);
    localparam int unsigned HIB_W  = $clog2(HIBER_LIMIT + 1);
    localparam int unsigned BAD_W  = $clog2(BER_THRESH + 1);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(SERDES_RST_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [HIB_W-1:0]  HIB_LAST  = HIB_W'(HIBER_LIMIT - 1);
    localparam logic [BAD_W-1:0]  THRESH    = BAD_W'(BER_THRESH);

    link_state_e          state_q, state_d;
    logic [RST_W-1:0]     rst_tmr_q, rst_tmr_d;
    logic [LOCK_W-1:0]    lock_tmr_q, lock_tmr_d;
    logic [HIB_W-1:0]     hiber_cnt_q, hiber_cnt_d;
    logic [CNT_WIDTH-1:0] retry_q, retry_d;
    logic [CNT_WIDTH-1:0] relock_q, relock_d;
    logic                 serdes_rst_q, serdes_rst_d;
    logic                 aligner_rst_q, aligner_rst_d;
    logic                 status_q, status_d;
    logic                 high_ber_q, high_ber_d;

    logic                 retry_inc, relock_inc;
    logic                 bad_hdr, mon_clear, mon_en;
    logic                 window_end, thresh_hit;
    logic [BAD_W-1:0]     bad_cnt;

    assign bad_hdr = i_rx_block_lock
                   && (i_rx_hdr != HDR_WIDTH'(SYNC_DATA))
                   && (i_rx_hdr != HDR_WIDTH'(SYNC_CTRL));

    assign mon_en    = (state_q == QUALIFY) || (state_q == UP) || (state_q == HI_BER);
    assign mon_clear = (state_d == QUALIFY) && (state_q != QUALIFY);

    eth_phy_10g_ber_mon #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber_mon (
        .clk        (clk),
        .rst        (rst),
        .clear      (mon_clear),
        .enable     (mon_en),
        .bad        (bad_hdr),
        .window_end (window_end),
        .bad_cnt    (bad_cnt),
        .thresh_hit (thresh_hit)
    );

    always_comb begin
        state_d     = state_q;
        hiber_cnt_d = hiber_cnt_q;
        retry_inc   = 1'b0;
        relock_inc  = 1'b0;

        case (state_q)
            RESET: begin
                if (rst_tmr_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (i_rx_block_lock) begin
                    state_d = QUALIFY;
                end else if (lock_tmr_q == LOCK_LAST) begin
                    state_d   = RESET;
                    retry_inc = 1'b1;
                end
            end
            QUALIFY: begin
                if (!i_rx_block_lock) begin
                    state_d = WAIT_LOCK;
                end else if (window_end && (bad_cnt < THRESH)) begin
                    state_d = UP;
                end
            end
            UP: begin
                if (!i_rx_block_lock) begin
                    state_d    = WAIT_LOCK;
                    relock_inc = 1'b1;
                end else if (thresh_hit) begin
                    state_d     = HI_BER;
                    hiber_cnt_d = '0;
                end
            end
            HI_BER: begin
                if (!i_rx_block_lock) begin
                    state_d    = WAIT_LOCK;
                    relock_inc = 1'b1;
                end else if (window_end) begin
                    if (bad_cnt < THRESH) begin
                        state_d = UP;
                    end else if (hiber_cnt_q >= HIB_LAST) begin
                        state_d   = RESET;
                        retry_inc = 1'b1;
                    end else begin
                        hiber_cnt_d = hiber_cnt_q + HIB_W'(1);
                    end
                end
            end
            default: state_d = RESET;
        endcase

        if (i_force_resync) begin
            state_d     = RESET;
            hiber_cnt_d = hiber_cnt_q;
            retry_inc   = 1'b1;
            relock_inc  = 1'b0;
        end

        // timers restart whenever their state is (re)entered
        rst_tmr_d = '0;
        if ((state_q == RESET) && (state_d == RESET) && !i_force_resync) begin
            rst_tmr_d = rst_tmr_q + RST_W'(1);
        end
        lock_tmr_d = '0;
        if ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK)) begin
            lock_tmr_d = lock_tmr_q + LOCK_W'(1);
        end

        retry_d  = (retry_inc && (retry_q != '1)) ? retry_q + CNT_WIDTH'(1) : retry_q;
        relock_d = (relock_inc && (relock_q != '1)) ? relock_q + CNT_WIDTH'(1) : relock_q;

        serdes_rst_d  = (state_d == RESET);
        aligner_rst_d = (state_d == RESET);
        status_d      = (state_d == UP);
        high_ber_d    = (state_d == HI_BER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RESET;
            rst_tmr_q     <= '0;
            lock_tmr_q    <= '0;
            hiber_cnt_q   <= '0;
            retry_q       <= '0;
            relock_q      <= '0;
            serdes_rst_q  <= 1'b1;
            aligner_rst_q <= 1'b1;
            status_q      <= 1'b0;
            high_ber_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_tmr_q     <= rst_tmr_d;
            lock_tmr_q    <= lock_tmr_d;
            hiber_cnt_q   <= hiber_cnt_d;
            retry_q       <= retry_d;
            relock_q      <= relock_d;
            serdes_rst_q  <= serdes_rst_d;
            aligner_rst_q <= aligner_rst_d;
            status_q      <= status_d;
            high_ber_q    <= high_ber_d;
        end
    end

    assign o_serdes_rx_reset = serdes_rst_q;
    assign o_aligner_rst     = aligner_rst_q;
    assign o_rx_status       = status_q;
    assign o_rx_high_ber     = high_ber_q;
    assign o_retry_count     = retry_q;
    assign o_relock_count    = relock_q;

endmodule
